// File: rtl/dctq_zigzag_reader.sv
// dctq_zigzag_reader: captures quantized DCT coefficients in raster order into
// a two-bank ping-pong store and streams each completed 8x8 block downstream
// in JPEG zigzag order. While both banks hold unread blocks, hold freezes the
// upstream DCTQ controller.
//
// Output handshake: out_valid/out_data/out_index/out_last form one registered
// beat. A beat transfers on a rising edge where out_valid && out_ready. While
// out_valid is high and out_ready is low, every output and the read counter
// hold their values. The output register may load a new beat whenever
// !out_valid || out_ready.
module dctq_zigzag_reader #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dctq_valid,
    input  logic [5:0]        dctq_addr,
    input  logic [DATA_W-1:0] dctq_data,
    output logic              hold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_index,
    output logic              out_last
);

    // Zigzag scan position -> raster index (row*8+col).
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [2][64];
    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank;
    logic              rd_bank;
    logic [5:0]        rd_cnt;
    logic              wr_en;
    logic              advance;
    logic              rd_done;

    assign hold    = full[wr_bank];
    assign wr_en   = dctq_valid && !hold;
    assign advance = !out_valid || out_ready;
    // The beat carrying scan position 63 is being loaded: the bank is drained.
    assign rd_done = (state == STREAM) && advance && (rd_cnt == 6'd63);

    // Per-bank full flag updates; set and clear always target different banks.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (wr_en && (dctq_addr == 6'd63)) begin
            full_set[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_clr[rd_bank] = 1'b1;
        end
    end

    // Coefficient storage; contents survive reset and are simply overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][dctq_addr] <= dctq_data;
        end
    end

    // Write-side bookkeeping: a write to raster 63 closes the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (wr_en && (dctq_addr == 6'd63)) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM with registered output beat; walks one bank in zigzag order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= 6'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 6'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (advance) begin
                        out_valid <= 1'b0;
                    end
                    if (full[rd_bank]) begin
                        state  <= STREAM;
                        rd_cnt <= 6'd0;
                    end
                end
                STREAM: begin
                    if (advance) begin
                        out_valid <= 1'b1;
                        out_data  <= mem[rd_bank][ZZ[rd_cnt]];
                        out_index <= rd_cnt;
                        out_last  <= (rd_cnt == 6'd63);
                        rd_cnt    <= rd_cnt + 6'd1;
                        if (rd_cnt == 6'd63) begin
                            rd_bank <= ~rd_bank;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
